// File: rtl/boot_pkg.sv
// Shared state encoding for the boot/debug sequencer; state_o exposes these values.
package boot_pkg;
    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_HALT  = 3'd3,
        S_STEP  = 3'd4
    } boot_state_e;
endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into little-endian words; word_valid pulses in the cycle the
// final byte of a word (or the image's last byte) is accepted, upper bytes zero-padded.
module byte_packer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             word_valid,
    output logic [WIDTH-1:0] word
);
    localparam int NB = WIDTH / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] acc;

    // Byte 0 starts from zero, so a short final word comes out zero-padded.
    always_comb begin
        word = (idx == '0) ? '0 : acc;
        word[8*idx +: 8] = in_data;
        word_valid = in_valid && (in_last || (idx == IW'(NB - 1)));
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx <= '0;
            acc <= '0;
        end else if (in_valid) begin
            idx <= word_valid ? '0 : idx + IW'(1);
            acc <= word;
        end
    end
endmodule

// File: rtl/core_boot_ctrl.sv
// Program loader and run/debug sequencer for the single-cycle core.
// Optional BOOT_BREAKPOINT_EN adds a single PC breakpoint (bp_valid/bp_addr).
//
// state | meaning
// LOAD  | core in reset, accepting image bytes into instruction memory
// START | one-cycle gap after the image, core still in reset
// RUN   | core executing freely
// HALT  | core stalled, waiting for step/resume/load
// STEP  | core executes exactly one instruction, then HALT
module core_boot_ctrl
    import boot_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_valid,
    input  logic [7:0]       ld_data,
    input  logic             ld_last,
    output logic             ld_ready,
    output logic             imem_we,
    output logic [DEPTH-3:0] imem_addr,
    output logic [WIDTH-1:0] imem_wdata,
    output logic             core_rst,
    output logic             core_en,
    input  logic [WIDTH-1:0] pc_in,
    input  logic             dbg_halt,
    input  logic             dbg_step,
    input  logic             dbg_resume,
    input  logic             dbg_load,
    output logic [2:0]       state_o,
    output logic [WIDTH-1:0] instret,
    output logic             load_err
`ifdef BOOT_BREAKPOINT_EN
    ,
    input  logic             bp_valid,
    input  logic [WIDTH-1:0] bp_addr
`endif
);
    localparam int AW = DEPTH - 2;

    boot_state_e      state, state_nxt;
    logic             byte_acc, word_valid, enter_load, full, step_hold, bp_hit;
    logic [WIDTH-1:0] word;
    logic [AW-1:0]    ptr;

    assign byte_acc   = ld_valid && ld_ready;
    assign enter_load = (state != S_LOAD) && (state_nxt == S_LOAD);
    assign state_o    = state;

    byte_packer #(.WIDTH(WIDTH)) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (enter_load),
        .in_valid   (byte_acc),
        .in_data    (ld_data),
        .in_last    (ld_last),
        .word_valid (word_valid),
        .word       (word)
    );

`ifdef BOOT_BREAKPOINT_EN
    // Skip the compare on the first cycle out of HALT so a resume can pass the breakpoint.
    logic bp_skip;
    always_ff @(posedge clk) begin
        if (rst) bp_skip <= 1'b0;
        else     bp_skip <= (state == S_HALT);
    end
    assign bp_hit = (state == S_RUN) && bp_valid && (pc_in == bp_addr) && !bp_skip;
`else
    logic unused_pc;
    assign unused_pc = ^pc_in;
    assign bp_hit    = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        ld_ready  = (state == S_LOAD);
        core_en   = ((state == S_RUN) && !bp_hit) || (state == S_STEP);
        case (state)
            S_LOAD:  if (byte_acc && ld_last) state_nxt = S_START;
            S_START: state_nxt = S_RUN;
            S_RUN: begin
                if (dbg_load)                state_nxt = S_LOAD;
                else if (dbg_halt || bp_hit) state_nxt = S_HALT;
            end
            S_HALT: begin
                if (dbg_load)                     state_nxt = S_LOAD;
                else if (dbg_step && !step_hold)  state_nxt = S_STEP;
                else if (dbg_resume)              state_nxt = S_RUN;
            end
            S_STEP:  state_nxt = S_HALT;
            default: state_nxt = S_LOAD;
        endcase
    end

    // A held dbg_step yields one step; it must drop before another is taken.
    always_ff @(posedge clk) begin
        if (rst)                   step_hold <= 1'b0;
        else if (state == S_STEP)  step_hold <= 1'b1;
        else if (!dbg_step)        step_hold <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_LOAD;
            ptr        <= '0;
            full       <= 1'b0;
            load_err   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst   <= 1'b1;
            instret    <= '0;
        end else begin
            state    <= state_nxt;
            core_rst <= (state_nxt == S_LOAD) || (state_nxt == S_START);
            imem_we  <= 1'b0;
            if (enter_load) begin
                ptr      <= '0;
                full     <= 1'b0;
                load_err <= 1'b0;
                instret  <= '0;
            end else begin
                if (core_en) instret <= instret + WIDTH'(1);
                if (word_valid) begin
                    if (full) begin
                        load_err <= 1'b1;
                    end else begin
                        imem_we    <= 1'b1;
                        imem_addr  <= ptr;
                        imem_wdata <= word;
                        ptr        <= ptr + AW'(1);
                        if (&ptr) full <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_core_boot_ctrl.sv
// Self-checking bench for core_boot_ctrl: expected imem writes are queued as bytes
// are driven and popped by a write monitor; control behaviour is checked inline.
module tb_core_boot_ctrl;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ld_valid = 1'b0, ld_last = 1'b0;
    logic [7:0]       ld_data = 8'h00;
    logic             ld_ready, imem_we, core_rst, core_en, load_err;
    logic [DEPTH-3:0] imem_addr;
    logic [WIDTH-1:0] imem_wdata, instret;
    logic [WIDTH-1:0] pc_in = '0;
    logic             dbg_halt = 1'b0, dbg_step = 1'b0, dbg_resume = 1'b0, dbg_load = 1'b0;
    logic [2:0]       state_o;
`ifdef BOOT_BREAKPOINT_EN
    logic             bp_valid = 1'b0;
    logic [WIDTH-1:0] bp_addr = '0;
`endif

    typedef struct {
        logic [DEPTH-3:0] addr;
        logic [WIDTH-1:0] data;
    } wr_t;
    wr_t exp_q[$];
    wr_t exp_w;

    int n_vec = 0;
    int n_err = 0;

    core_boot_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .core_en    (core_en),
        .pc_in      (pc_in),
        .dbg_halt   (dbg_halt),
        .dbg_step   (dbg_step),
        .dbg_resume (dbg_resume),
        .dbg_load   (dbg_load),
        .state_o    (state_o),
        .instret    (instret),
        .load_err   (load_err)
`ifdef BOOT_BREAKPOINT_EN
        ,
        .bp_valid   (bp_valid),
        .bp_addr    (bp_addr)
`endif
    );

    always #5 clk = ~clk;

    // Write monitor: every imem write must match the head of the expected queue.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", imem_addr, imem_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                if (imem_addr !== exp_w.addr || imem_wdata !== exp_w.data) begin
                    n_err++;
                    $display("FAIL imem_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                             imem_addr, imem_wdata, exp_w.addr, exp_w.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        ld_valid = 1'b1;
        ld_data  = b;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic reload;
        dbg_load = 1'b1;
        tick();
        dbg_load = 1'b0;
        @(negedge clk);
        n_vec++; if (state_o !== 3'd0) begin n_err++; $display("FAIL reload_state: got %0d expected 0", state_o); end
        n_vec++; if (instret !== '0) begin n_err++; $display("FAIL reload_instret: got %0d expected 0", instret); end
        n_vec++; if (load_err !== 1'b0) begin n_err++; $display("FAIL reload_err: got %b expected 0", load_err); end
        n_vec++; if (core_rst !== 1'b1) begin n_err++; $display("FAIL reload_core_rst: got %b expected 1", core_rst); end
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        n_vec++; if (state_o !== 3'd0) begin n_err++; $display("FAIL rst_state: got %0d expected 0", state_o); end
        n_vec++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL rst_ld_ready: got %b expected 1", ld_ready); end
        n_vec++; if (imem_we !== 1'b0) begin n_err++; $display("FAIL rst_imem_we: got %b expected 0", imem_we); end
        n_vec++; if (imem_addr !== '0) begin n_err++; $display("FAIL rst_imem_addr: got %0d expected 0", imem_addr); end
        n_vec++; if (imem_wdata !== '0) begin n_err++; $display("FAIL rst_imem_wdata: got %h expected 0", imem_wdata); end
        n_vec++; if (core_rst !== 1'b1) begin n_err++; $display("FAIL rst_core_rst: got %b expected 1", core_rst); end
        n_vec++; if (core_en !== 1'b0) begin n_err++; $display("FAIL rst_core_en: got %b expected 0", core_en); end
        n_vec++; if (instret !== '0) begin n_err++; $display("FAIL rst_instret: got %0d expected 0", instret); end
        n_vec++; if (load_err !== 1'b0) begin n_err++; $display("FAIL rst_load_err: got %b expected 0", load_err); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single_word;
        exp_q.push_back('{addr: '0, data: 32'h0010_0513});
        send_byte(8'h13, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h00, 1'b1);
        @(negedge clk);
        n_vec++; if (imem_we !== 1'b1) begin n_err++; $display("FAIL basic_we_timing: got %b expected 1", imem_we); end
        n_vec++; if (state_o !== 3'd1) begin n_err++; $display("FAIL basic_start: got %0d expected 1", state_o); end
        n_vec++; if (core_rst !== 1'b1) begin n_err++; $display("FAIL basic_start_rst: got %b expected 1", core_rst); end
        n_vec++; if (core_en !== 1'b0) begin n_err++; $display("FAIL basic_start_en: got %b expected 0", core_en); end
        tick();
        @(negedge clk);
        n_vec++; if (state_o !== 3'd2) begin n_err++; $display("FAIL basic_run: got %0d expected 2", state_o); end
        n_vec++; if (core_rst !== 1'b0) begin n_err++; $display("FAIL basic_run_rst: got %b expected 0", core_rst); end
        n_vec++; if (core_en !== 1'b1) begin n_err++; $display("FAIL basic_run_en: got %b expected 1", core_en); end
        tick();
    endtask

    task automatic test_partial_word;
        logic [7:0] img [6];
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB};
        reload();
        exp_q.push_back('{addr: 2'd0, data: 32'h0403_0201});
        exp_q.push_back('{addr: 2'd1, data: 32'h0000_BBAA});
        for (int i = 0; i < 6; i++) begin
            ld_valid = 1'b1;
            ld_data  = img[i];
            ld_last  = (i == 5);
            @(negedge clk);
            n_vec++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, ld_ready); end
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        tick();
        @(negedge clk);
        n_vec++; if (state_o !== 3'd2) begin n_err++; $display("FAIL partial_run: got %0d expected 2", state_o); end
        tick();
    endtask

    task automatic test_overflow;
        logic [7:0] b;
        reload();
        for (int w = 0; w < 5; w++) begin
            if (w < 4)
                exp_q.push_back('{addr: 2'(w), data: {8'(16*w+3), 8'(16*w+2), 8'(16*w+1), 8'(16*w)}});
            for (int k = 0; k < 4; k++) begin
                b = 8'(16*w + k);
                send_byte(b, (w == 4) && (k == 3));
            end
        end
        @(negedge clk);
        n_vec++; if (load_err !== 1'b1) begin n_err++; $display("FAIL ovf_err: got %b expected 1", load_err); end
        tick();
        @(negedge clk);
        n_vec++; if (state_o !== 3'd2) begin n_err++; $display("FAIL ovf_run: got %0d expected 2", state_o); end
        n_vec++; if (load_err !== 1'b1) begin n_err++; $display("FAIL ovf_err_sticky: got %b expected 1", load_err); end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL ovf_writes: got %0d missing writes expected 0", exp_q.size()); end
        tick();
    endtask

    task automatic test_halt_step;
        logic [WIDTH-1:0] i0;
        i0 = instret;
        dbg_halt = 1'b1;
        @(negedge clk);
        n_vec++; if (core_en !== 1'b1) begin n_err++; $display("FAIL halt_cycle_en: got %b expected 1", core_en); end
        tick();
        dbg_halt = 1'b0;
        @(negedge clk);
        n_vec++; if (state_o !== 3'd3) begin n_err++; $display("FAIL halt_state: got %0d expected 3", state_o); end
        n_vec++; if (core_en !== 1'b0) begin n_err++; $display("FAIL halt_en: got %b expected 0", core_en); end
        dbg_step = 1'b1;
        repeat (3) tick();
        dbg_step = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        n_vec++; if (instret !== i0 + 2) begin n_err++; $display("FAIL step_instret: got %0d expected %0d", instret, i0 + 2); end
        n_vec++; if (state_o !== 3'd3) begin n_err++; $display("FAIL step_end_state: got %0d expected 3", state_o); end
        tick();
    endtask

`ifdef BOOT_BREAKPOINT_EN
    task automatic test_breakpoint;
        logic [WIDTH-1:0] i1;
        bp_valid   = 1'b1;
        bp_addr    = 32'h8;
        pc_in      = 32'h0;
        dbg_resume = 1'b1;
        tick();
        dbg_resume = 1'b0;
        tick();
        pc_in = 32'h8;
        i1 = instret;
        @(negedge clk);
        n_vec++; if (core_en !== 1'b0) begin n_err++; $display("FAIL bp_en: got %b expected 0", core_en); end
        tick();
        @(negedge clk);
        n_vec++; if (state_o !== 3'd3) begin n_err++; $display("FAIL bp_halt: got %0d expected 3", state_o); end
        n_vec++; if (instret !== i1) begin n_err++; $display("FAIL bp_no_retire: got %0d expected %0d", instret, i1); end
        dbg_resume = 1'b1;
        tick();
        dbg_resume = 1'b0;
        @(negedge clk);
        n_vec++; if (core_en !== 1'b1) begin n_err++; $display("FAIL bp_resume_en: got %b expected 1", core_en); end
        tick();
        pc_in = 32'hC;
        @(negedge clk);
        n_vec++; if (instret !== i1 + 1) begin n_err++; $display("FAIL bp_resume_instret: got %0d expected %0d", instret, i1 + 1); end
        n_vec++; if (state_o !== 3'd2) begin n_err++; $display("FAIL bp_no_rehalt: got %0d expected 2", state_o); end
        bp_valid = 1'b0;
        tick();
    endtask
`endif

    task automatic test_rst_mid_load;
        reload();
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.push_back('{addr: 2'd0, data: 32'h4433_2211});
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        @(negedge clk);
        n_vec++; if (state_o !== 3'd1) begin n_err++; $display("FAIL rst_load_start: got %0d expected 1", state_o); end
        repeat (3) tick();
        @(negedge clk);
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rst_load_writes: got %0d missing writes expected 0", exp_q.size()); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_partial_word();
        test_overflow();
        test_halt_step();
`ifdef BOOT_BREAKPOINT_EN
        test_breakpoint();
`endif
        test_rst_mid_load();
        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
